// File: rtl/raster_scheduler_pkg.sv
// raster_pkg: shared state encoding, vertex/triangle types and vertex word field layout
package raster_pkg;
  localparam int COORD_WIDTH = 32;
  localparam int X_LSB = 0;
  localparam int Y_LSB = COORD_WIDTH;
  localparam int Z_LSB = 2 * COORD_WIDTH;
  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    CLEAR       = 3'd1,
    WAIT_CLEAR  = 3'd2,
    FETCH       = 3'd3,
    LAUNCH      = 3'd4,
    WAIT_ENGINE = 3'd5,
    DONE        = 3'd6
  } sched_state_t;
  typedef logic [2:0][COORD_WIDTH-1:0] vertex_t;
  typedef logic [2:0][2:0][COORD_WIDTH-1:0] triangle_t;
  function automatic vertex_t unpack_vertex(input logic [3*COORD_WIDTH-1:0] w);
    unpack_vertex[0] = w[X_LSB +: COORD_WIDTH];
    unpack_vertex[1] = w[Y_LSB +: COORD_WIDTH];
    unpack_vertex[2] = w[Z_LSB +: COORD_WIDTH];
  endfunction
endpackage

// File: rtl/raster_scheduler_if.sv
// raster_scheduler_if: vertex memory, clear engine and rasterizer engine handshake bundle
interface raster_scheduler_if import raster_pkg::*; #(parameter int TRI_ADDR_W = 10);
  logic [TRI_ADDR_W+1:0] vmem_addr;
  logic [3*COORD_WIDTH-1:0] vmem_rdata;
  triangle_t tri_verts;
  logic engine_start;
  logic engine_done;
  logic engine_valid;
  logic clear_start;
  logic clear_done;
  modport master (
    output vmem_addr, tri_verts, engine_start, clear_start,
    input  vmem_rdata, engine_done, engine_valid, clear_done
  );
  modport slave (
    input  vmem_addr, tri_verts, engine_start, clear_start,
    output vmem_rdata, engine_done, engine_valid, clear_done
  );
endinterface

// File: rtl/raster_scheduler_vertex_fetch.sv
// vertex_fetch: issues three vertex addresses and captures each word READ_LATENCY cycles later
module vertex_fetch import raster_pkg::*; #(
  parameter int AW = 12,
  parameter int READ_LATENCY = 2
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic start,
  input  logic [AW-1:0] base_addr,
  input  logic [3*COORD_WIDTH-1:0] rdata,
  output logic [AW-1:0] addr,
  output triangle_t tri_o,
  output logic done
);
  localparam int PW = 2 * READ_LATENCY;
  logic [1:0] cnt_q, cnt_d;
  logic act_q, act_d, issue;
  logic [READ_LATENCY-1:0] pv_q, pv_d;
  logic [READ_LATENCY-1:0][1:0] pi_q, pi_d;
  triangle_t tri_q, tri_d;
  // Address sequencer plus a tag pipeline that marks which vertex the returning word belongs to
  always_comb begin
    issue = act_q && cnt_q != 2'd3;
    addr = base_addr + AW'(cnt_q);
    done = pv_q[READ_LATENCY-1] && pi_q[READ_LATENCY-1] == 2'd2;
    act_d = start || (act_q && !done);
    cnt_d = start ? 2'd0 : cnt_q + 2'(issue);
    pv_d = (pv_q << 1) | READ_LATENCY'(issue);
    pi_d = (pi_q << 2) | PW'(cnt_q);
    tri_d = tri_q;
    if (pv_q[READ_LATENCY-1]) tri_d[pi_q[READ_LATENCY-1]] = unpack_vertex(rdata);
  end
  // Sequencer, pipeline and captured triangle registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q <= '0;
      act_q <= 1'b0;
      pv_q <= '0;
      pi_q <= '0;
      tri_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      act_q <= act_d;
      pv_q <= pv_d;
      pi_q <= pi_d;
      tri_q <= tri_d;
    end
  end
  assign tri_o = tri_q;
endmodule

// File: rtl/raster_scheduler.sv
// raster_scheduler: per-frame sequencer of clear, vertex fetch and rasterizer launches with watchdog
module raster_scheduler import raster_pkg::*; #(
  parameter int TRI_ADDR_W = 10,
  parameter int READ_LATENCY = 2,
  parameter bit CLEAR_EN = 1'b1,
  parameter int TIMEOUT = 2**20
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic frame_start,
  input  logic [TRI_ADDR_W-1:0] tri_count,
  raster_scheduler_if.master bus,
  output logic busy,
  output logic frame_done,
  output logic aborted,
  output logic [TRI_ADDR_W-1:0] drawn_count,
  output logic [TRI_ADDR_W-1:0] culled_count,
  output logic [2:0] sched_state
);
  localparam int AW = TRI_ADDR_W + 2;
  localparam int WW = $clog2(TIMEOUT + 1);
  sched_state_t state_q, state_d;
  logic [TRI_ADDR_W-1:0] tri_total_q, tri_total_d, tri_idx_q, tri_idx_d;
  logic [TRI_ADDR_W-1:0] drawn_q, drawn_d, culled_q, culled_d;
  logic [AW-1:0] base_q, base_d, fetch_addr;
  logic [WW-1:0] wd_q, wd_d;
  logic abort_q, abort_d, wd_hit, fetch_start, fetch_done;
  triangle_t fetch_tri;
  // Next-state, frame bookkeeping and watchdog; watchdog restarts whenever a wait state is entered
  always_comb begin
    state_d = state_q;
    tri_total_d = tri_total_q;
    tri_idx_d = tri_idx_q;
    drawn_d = drawn_q;
    culled_d = culled_q;
    base_d = base_q;
    abort_d = abort_q;
    wd_d = (state_q == WAIT_CLEAR || state_q == WAIT_ENGINE) ? wd_q + WW'(1) : '0;
    wd_hit = wd_q == WW'(TIMEOUT - 1);
    case (state_q)
      IDLE: if (frame_start) begin
        tri_total_d = tri_count;
        tri_idx_d = '0;
        base_d = '0;
        drawn_d = '0;
        culled_d = '0;
        abort_d = 1'b0;
        state_d = CLEAR_EN ? CLEAR : tri_count == '0 ? DONE : FETCH;
      end
      CLEAR: state_d = !bus.clear_done ? WAIT_CLEAR : tri_total_q == '0 ? DONE : FETCH;
      WAIT_CLEAR: if (bus.clear_done) state_d = tri_total_q == '0 ? DONE : FETCH;
        else if (wd_hit) begin
          abort_d = 1'b1;
          state_d = DONE;
        end
      FETCH: if (fetch_done) state_d = LAUNCH;
      LAUNCH: state_d = WAIT_ENGINE;
      WAIT_ENGINE: if (bus.engine_done) begin
          drawn_d = drawn_q + TRI_ADDR_W'(bus.engine_valid);
          culled_d = culled_q + TRI_ADDR_W'(!bus.engine_valid);
          tri_idx_d = tri_idx_q + TRI_ADDR_W'(1);
          base_d = base_q + AW'(3);
          state_d = tri_idx_d == tri_total_q ? DONE : FETCH;
        end else if (wd_hit) begin
          abort_d = 1'b1;
          state_d = DONE;
        end
      default: state_d = IDLE;
    endcase
  end
  // Frame state registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      tri_total_q <= '0;
      tri_idx_q <= '0;
      drawn_q <= '0;
      culled_q <= '0;
      base_q <= '0;
      abort_q <= 1'b0;
      wd_q <= '0;
    end else begin
      state_q <= state_d;
      tri_total_q <= tri_total_d;
      tri_idx_q <= tri_idx_d;
      drawn_q <= drawn_d;
      culled_q <= culled_d;
      base_q <= base_d;
      abort_q <= abort_d;
      wd_q <= wd_d;
    end
  end
  assign fetch_start = state_d == FETCH && state_q != FETCH;
  vertex_fetch #(.AW(AW), .READ_LATENCY(READ_LATENCY)) u_fetch (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .start(fetch_start),
    .base_addr(base_q),
    .rdata(bus.vmem_rdata),
    .addr(fetch_addr),
    .tri_o(fetch_tri),
    .done(fetch_done)
  );
  assign bus.vmem_addr = fetch_addr;
  assign bus.tri_verts = fetch_tri;
  assign bus.clear_start = state_q == CLEAR;
  assign bus.engine_start = state_q == LAUNCH;
  assign frame_done = state_q == DONE;
  assign busy = state_q != IDLE && state_q != DONE;
  assign aborted = abort_q;
  assign drawn_count = drawn_q;
  assign culled_count = culled_q;
  assign sched_state = state_q;
endmodule

// File: tb/tb_raster_scheduler.sv
// tb_raster_scheduler: scoreboard bench for clear, fetch, launch, tally, watchdog and reset behaviour
module tb_raster_scheduler;
  localparam int TW = 10;
  localparam int RL = 2;
  localparam int TO = 64;
  typedef struct {int kind; int a; int b; int c; int d;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
  logic [TW-1:0] tri_count = '0;
  logic busy, frame_done, aborted;
  logic [TW-1:0] drawn_count, culled_count;
  logic [2:0] sched_state;
  logic [TW+1:0] a1 = '0, a2 = '0;
  logic [TW+1:0] alog [3];
  logic [31:0] x_w;
  logic [2:0] prev_st = '0;
  exp_t exp_q [$];
  int valid_q [$];
  int n_run = 0, n_fail = 0, frames_seen = 0, cyc = 0, t_we = 0, fl = 0;
  int clr_delay = -1, eng_delay = -1;
  raster_scheduler_if #(.TRI_ADDR_W(TW)) bus();
  raster_scheduler #(.TRI_ADDR_W(TW), .READ_LATENCY(RL), .CLEAR_EN(1'b1), .TIMEOUT(TO)) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .frame_start(frame_start),
    .tri_count(tri_count),
    .bus(bus),
    .busy(busy),
    .frame_done(frame_done),
    .aborted(aborted),
    .drawn_count(drawn_count),
    .culled_count(culled_count),
    .sched_state(sched_state)
  );
  always #5 clk = ~clk;
  // Vertex BRAM: two-cycle latency, word for address A is {A<<16 + 2, A<<16 + 1, A<<16}
  always @(posedge clk) begin
    a1 <= bus.vmem_addr;
    a2 <= a1;
    cyc <= cyc + 1;
  end
  assign x_w = 32'(a2) << 16;
  assign bus.vmem_rdata = {x_w + 32'd2, x_w + 32'd1, x_w};
  task automatic chk(input string nm, input longint act, input longint exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // Clear engine responder
  initial begin
    bus.clear_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.clear_start && clr_delay >= 0) begin
        repeat (clr_delay) @(posedge clk);
        #1 bus.clear_done = 1'b1;
        @(posedge clk);
        #1 bus.clear_done = 1'b0;
      end
    end
  end
  // Rasterizer engine responder
  initial begin
    bus.engine_done = 1'b0;
    bus.engine_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.engine_start && eng_delay >= 0) begin
        repeat (eng_delay) @(posedge clk);
        #1 bus.engine_done = 1'b1;
        bus.engine_valid = (valid_q.size() != 0) ? valid_q.pop_front() != 0 : 1'b1;
        @(posedge clk);
        #1 bus.engine_done = 1'b0;
        bus.engine_valid = 1'b0;
      end
    end
  end
  // Monitor: pops the scoreboard on every clear_start, engine_start and frame_done
  always @(negedge clk) begin
    exp_t e;
    int ev;
    if (rst_n) begin
      if (sched_state == 3'd5 && prev_st != 3'd5) t_we = cyc;
      if (sched_state == 3'd3) begin
        if (prev_st != 3'd3) fl = 0;
        if (fl < 3) alog[fl] = bus.vmem_addr;
        fl++;
      end
      if (bus.clear_start || bus.engine_start || frame_done) begin
        ev = frame_done ? 2 : bus.engine_start ? 1 : 0;
        if (exp_q.size() == 0) chk("unexpected_event", ev, -1);
        else begin
          e = exp_q.pop_front();
          chk("event_kind", ev, e.kind);
          if (ev == e.kind && ev == 1) begin
            chk("fetch_cycles", fl, 3 + RL);
            for (int v = 0; v < 3; v++) begin
              chk("vmem_addr", alog[v], e.a + v);
              chk("vert_x", bus.tri_verts[v][0], (e.a + v) << 16);
              chk("vert_y", bus.tri_verts[v][1], ((e.a + v) << 16) + 1);
              chk("vert_z", bus.tri_verts[v][2], ((e.a + v) << 16) + 2);
            end
          end
          if (ev == e.kind && ev == 2) begin
            chk("drawn_count", drawn_count, e.a);
            chk("culled_count", culled_count, e.b);
            chk("aborted", aborted, e.c);
            chk("busy_at_done", busy, 0);
            if (e.d >= 0) chk("abort_latency", cyc - t_we, e.d);
          end
        end
      end
      if (frame_done) frames_seen++;
    end
    prev_st = sched_state;
  end
  task automatic start_frame(input int n);
    @(posedge clk);
    #1 frame_start = 1'b1;
    tri_count = TW'(n);
    @(posedge clk);
    #1 frame_start = 1'b0;
  endtask
  task automatic run_frame(input int n, input int cd, input int ed, input int nl,
                           input int d, input int c, input int ab, input int lat);
    int f0;
    clr_delay = cd;
    eng_delay = ed;
    exp_q.push_back('{0, 0, 0, 0, -1});
    for (int i = 0; i < nl; i++) exp_q.push_back('{1, 3 * i, 0, 0, -1});
    exp_q.push_back('{2, d, c, ab, lat});
    f0 = frames_seen;
    start_frame(n);
    chk("busy_after_start", busy, 1);
    chk("aborted_cleared", aborted, 0);
    for (int k = 0; k < 3000 && frames_seen == f0; k++) @(negedge clk);
    chk("frame_done_seen", frames_seen - f0, 1);
    @(negedge clk);
    chk("busy_after_frame", busy, 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask
  initial begin
    int f0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_state", sched_state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_drawn", drawn_count, 0);
    chk("rst_culled", culled_count, 0);
    chk("rst_verts_zero", bus.tri_verts == '0, 1);
    chk("rst_engine_start", bus.engine_start, 0);
    chk("rst_clear_start", bus.clear_start, 0);
    valid_q = '{1, 1};
    run_frame(2, 5, 3, 2, 2, 0, 0, -1);
    valid_q = '{1, 0, 1};
    run_frame(3, 0, 3, 3, 2, 1, 0, -1);
    run_frame(0, 3, 3, 0, 0, 0, 0, -1);
    run_frame(2, 2, -1, 1, 0, 0, 1, TO);
    repeat (10) @(negedge clk);
    chk("aborted_sticky", aborted, 1);
    chk("idle_after_abort", sched_state, 0);
    valid_q = '{0};
    run_frame(1, 1, 2, 1, 0, 1, 0, -1);
    clr_delay = 2;
    eng_delay = -1;
    exp_q.push_back('{0, 0, 0, 0, -1});
    exp_q.push_back('{1, 0, 0, 0, -1});
    start_frame(2);
    for (int k = 0; k < 200 && sched_state != 3'd5; k++) @(negedge clk);
    chk("reached_wait_engine", sched_state, 5);
    @(posedge clk);
    #1 frame_start = 1'b1;
    tri_count = TW'(7);
    @(posedge clk);
    #1 frame_start = 1'b0;
    @(negedge clk);
    chk("busy_start_ignored_state", sched_state, 5);
    chk("busy_start_ignored_busy", busy, 1);
    f0 = frames_seen;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", sched_state, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_engine_start", bus.engine_start, 0);
    chk("async_rst_verts_zero", bus.tri_verts == '0, 1);
    chk("async_rst_drawn", drawn_count, 0);
    chk("async_rst_aborted", aborted, 0);
    exp_q.delete();
    valid_q.delete();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_frame_done_after_rst", frames_seen - f0, 0);
    chk("idle_after_rst", sched_state, 0);
    valid_q = '{1};
    run_frame(1, 2, 2, 1, 1, 0, 0, -1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
